// File: rtl/rca_seq_adder.sv
// Wide add/subtract built from one 4-bit ripple slice, one nibble per clock, LSB first.
// Latency: NIBBLES cycles from accept to done. start is only sampled in IDLE/DONE and is dropped while busy.

module rca4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic c;

  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

module rca_seq_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] s,
  output logic                 cout,
  output logic                 ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [W-1:0]    s_q, s_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [3:0]      sl_a, sl_b, sl_s;
  logic            sl_co;
  logic [W-1:0]    sum_full;
  logic            last;

  rca4_slice u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_q),
    .s  (sl_s),
    .co (sl_co)
  );

  // Working sum with the current slice result merged in; on the last slice this is the final result.
  always_comb begin
    sl_a     = a_q[{idx_q, 2'b00} +: 4];
    sl_b     = b_q[{idx_q, 2'b00} +: 4];
    sum_full = sum_q;
    sum_full[{idx_q, 2'b00} +: 4] = sl_s;
    last     = (idx_q == IW'(NIBBLES - 1));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {W{sub}};
          carry_d = cin ^ sub;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d   = sum_full;
        carry_d = sl_co;
        if (last) begin
          s_d     = sum_full;
          cout_d  = sl_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_full[W-1] != a_q[W-1]);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// Randomized and directed checks of rca_seq_adder (NIBBLES=4) against an arithmetic reference model.
module tb_rca_seq_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] s;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] last_s = '0;

  rca_seq_adder #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, s} from plain W+1-bit arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mci, input logic msub);
    logic [W-1:0] beff;
    logic [W:0]   full;
    logic         o;
    beff = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, beff} + {{W{1'b0}}, (mci ^ msub)};
    o    = (ma[W-1] == beff[W-1]) && (full[W-1] != ma[W-1]);
    return {o, full[W], full[W-1:0]};
  endfunction

  // Called just after an edge: present an op, let the next edge accept it, then scramble inputs.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ici, input logic isub);
    a = ia; b = ib; cin = ici; sub = isub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  // Runs from 1ns after the accepting edge through the done cycle.
  // poke: RUN cycle index at which a spurious start is pulsed (-1 = none).
  // hold: raise start with the next op during the last RUN cycle so it is accepted in DONE.
  task automatic finish(input string tag, input logic [W-1:0] es, input logic ec, input logic eo,
                        input int poke, input bit hold,
                        input logic [W-1:0] na, input logic [W-1:0] nb);
    for (int k = 0; k < N; k++) begin
      chk({tag, " busy"}, 64'(busy), 64'd1);
      chk({tag, " done_low"}, 64'(done), 64'd0);
      chk({tag, " s_hold"}, 64'(s), 64'(last_s));
      if (k == poke) begin
        a = 16'hAAAA; start = 1'b1;
      end
      if (hold && k == N - 1) begin
        a = na; b = nb; cin = 1'b0; sub = 1'b0; start = 1'b1;
      end
      @(posedge clk); #1;
      if (k == poke) start = 1'b0;
    end
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " busy_low"}, 64'(busy), 64'd0);
    chk({tag, " s"}, 64'(s), 64'(es));
    chk({tag, " cout"}, 64'(cout), 64'(ec));
    chk({tag, " ovf"}, 64'(ovf), 64'(eo));
    last_s = es;
    if (hold) begin
      @(posedge clk); #1;
      start = 1'b0;
    end else begin
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, 64'(done), 64'd0);
      chk({tag, " idle"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                    input logic ici, input logic isub,
                    input logic [W-1:0] es, input logic ec, input logic eo);
    issue(ia, ib, ici, isub);
    finish(tag, es, ec, eo, -1, 1'b0, '0, '0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    logic [W+1:0] m;

    rst = 1'b1;
    #12;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst s", 64'(s), 64'd0);
    chk("rst cout", 64'(cout), 64'd0);
    chk("rst ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    op("add",      16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    op("carry",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op("carry_ci", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
    op("sovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op("sovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    op("borrow",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Spurious start two cycles into RUN must be ignored and not queued.
    issue(16'h0001, 16'h0001, 1'b0, 1'b0);
    finish("mid_start", 16'h0002, 1'b0, 1'b0, 1, 1'b0, '0, '0);

    // Start held through DONE: back-to-back accept.
    issue(16'h0005, 16'h0006, 1'b0, 1'b0);
    finish("b2b_first", 16'h000B, 1'b0, 1'b0, -1, 1'b1, 16'h0010, 16'h0020);
    finish("b2b_second", 16'h0030, 1'b0, 1'b0, -1, 1'b0, '0, '0);

    // Asynchronous reset in the second RUN cycle.
    issue(16'h4321, 16'h1111, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst done", 64'(done), 64'd0);
    chk("arst s", 64'(s), 64'd0);
    chk("arst cout", 64'(cout), 64'd0);
    chk("arst ovf", 64'(ovf), 64'd0);
    last_s = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < N + 2; k++) begin
      @(posedge clk); #1;
      chk("arst no_done", 64'(done), 64'd0);
    end
    op("post_rst", 16'h1000, 16'h0234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      if (t % 8 == 0) rb = ra;
      m = model(ra, rb, rc, rs);
      op($sformatf("rand%0d", t), ra, rb, rc, rs, m[W-1:0], m[W], m[W+1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
